he_hssi_tc_mailbox: RTL
=======================

// Module: he_hssi_tc_mailbox
// PURPOSE
//  Mailbox bridge between the HE-HSSI AFU CSR block and the traffic controller (TG/TM/loopback)
//  register file. Host software uses four mailbox registers at TRAFFIC_CTRL_CMD_ADDR (CMD +0x0,
//  ADDRESS +0x4, RDDATA +0x8, WRDATA +0xC) to post one indirect register access at a time.
//  The block sequences that access onto the traffic controller's req/ack port, captures read
//  data and reports completion or timeout.
// PARAMETERS
//  TC_ADDR_W    16    traffic controller register index width (e.g. TG_NUM_PKT=0x00, TM_NUM_PKT=0x100)
//  DATA_W       32    mailbox and traffic controller data width
//  TIMEOUT_CYC  1024  cycles to wait for tc_ack before a timeout (must be >= 2)
// PORTS
//  clk            in   1         AFU clock
//  rst_n          in   1         asynchronous active-low reset
//  csr_wr         in   1         CSR write strobe, mailbox window
//  csr_rd         in   1         CSR read strobe, mailbox window
//  csr_addr       in   4         byte offset in mailbox (0x0,0x4,0x8,0xC; others decode to nothing)
//  csr_wdata      in   DATA_W    CSR write data
//  csr_rdata      out  DATA_W    CSR read data
//  csr_rdata_vld  out  1         read data valid pulse
//  tc_wr          out  1         traffic controller write request (1-cycle pulse)
//  tc_rd          out  1         traffic controller read request (1-cycle pulse)
//  tc_addr        out  TC_ADDR_W register index, stable from request until completion
//  tc_wdata       out  DATA_W    write data, stable from request until completion
//  tc_ack         in   1         access complete; tc_rdata is valid on the same cycle for reads
//  tc_rdata       in   DATA_W    read data
// BEHAVIOUR
//  Reset: all outputs 0. ADDRESS, WRDATA, RDDATA and the status flags are 0. FSM is IDLE.
//   Reset asserted mid-access drops tc_wr/tc_rd immediately and abandons the access.
//  CMD read layout: [0] rd, [1] wr, [2] ack (done), [3] busy, [4] err (timeout or illegal). Upper bits 0.
//  CSR reads: csr_rdata/csr_rdata_vld are registered, 1 cycle after csr_rd. An unmapped offset returns 0 with vld=1.
//  CSR writes:
//   - RDDATA and unmapped offsets: ignored.
//   - ADDRESS, WRDATA: ignored while busy. ADDRESS keeps bits [TC_ADDR_W-1:0].
//  Command accept (CMD write while IDLE):
//   - 0x1 (MB_RD) or 0x2 (MB_WR): clear ack/err, latch rd/wr, set busy, go to ISSUE.
//   - 0x0 (MB_NOOP): clear rd/wr/ack/err.
//   - 0x3: set ack=1, err=1, busy=0. Issue nothing.
//   - Only bits [1:0] are decoded.
//   - A CMD write while busy is ignored entirely.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE:
//   - ISSUE: one cycle. Pulse tc_rd or tc_wr, clear the timeout counter, go to WAIT.
//   - WAIT: count cycles.
//     * On tc_ack: for a read, RDDATA <= tc_rdata. Then set ack=1, busy=0 and go to IDLE.
//     * If the counter reaches TIMEOUT_CYC-1 with no ack: set ack=1, err=1, busy=0,
//       RDDATA <= {DATA_W{1'b1}} for reads, and go to IDLE.
//     * tc_ack wins if it arrives on the timeout cycle.
//   - tc_ack seen in IDLE or ISSUE is ignored.
//   - Latency: from the csr_wr of CMD to tc_rd/tc_wr is 1 cycle. From tc_ack to ack=1 is 1 cycle.
//  A CSR read of CMD and a completion in the same cycle: the read returns the pre-update value.
//  Only one access is outstanding at a time. There is no queueing.
// TESTING
//  1. Write ADDRESS=0x100, CMD=0x1. TC acks after 3 cycles with 0x0000_0040. Expect: tc_rd one
//     pulse, tc_addr=0x100; CMD reads 0x5; RDDATA reads 0x40.
//  2. Write ADDRESS=0x00, WRDATA=0x20, CMD=0x2. Expect: tc_wr one pulse, tc_wdata=0x20; on ack
//     CMD reads 0x6; RDDATA unchanged.
//  3. Issue a read and withhold tc_ack. Expect: exactly TIMEOUT_CYC cycles in WAIT, then
//     CMD=0x15 and RDDATA=0xFFFF_FFFF. A late tc_ack afterwards changes nothing.
//  4. While busy, write ADDRESS=0x200 and CMD=0x2. Expect: both ignored; tc_addr keeps its old
//     value; no second request. Write CMD=0x3 in IDLE: CMD reads 0x17 (low bits latched),
//     no tc request.
//  5. Assert rst_n=0 during WAIT. Expect: tc_rd/tc_wr=0 immediately, all mailbox registers 0,
//     and a fresh CMD=0x1 after reset works normally.
//  6. Drive tc_ack on the final timeout cycle. Expect: normal completion, err=0, RDDATA=tc_rdata.

Source files
------------

// File: rtl/he_hssi_tc_mailbox_if.sv
// Mailbox bus bundle: host-side CSR window plus the traffic controller req/ack port.
// The slave view belongs to the mailbox; the master view drives CSRs and plays the traffic controller.
interface he_hssi_tc_mailbox_if #(
   parameter int TC_ADDR_W = 16,
   parameter int DATA_W    = 32
);
   logic                 csr_wr;
   logic                 csr_rd;
   logic [3:0]           csr_addr;
   logic [DATA_W-1:0]    csr_wdata;
   logic [DATA_W-1:0]    csr_rdata;
   logic                 csr_rdata_vld;
   logic                 tc_wr;
   logic                 tc_rd;
   logic [TC_ADDR_W-1:0] tc_addr;
   logic [DATA_W-1:0]    tc_wdata;
   logic                 tc_ack;
   logic [DATA_W-1:0]    tc_rdata;

   modport slave (
      input  csr_wr, csr_rd, csr_addr, csr_wdata, tc_ack, tc_rdata,
      output csr_rdata, csr_rdata_vld, tc_wr, tc_rd, tc_addr, tc_wdata
   );

   modport master (
      output csr_wr, csr_rd, csr_addr, csr_wdata, tc_ack, tc_rdata,
      input  csr_rdata, csr_rdata_vld, tc_wr, tc_rd, tc_addr, tc_wdata
   );
endinterface

// File: rtl/he_hssi_tc_mailbox.sv
// Indirect register access bridge: one host-posted read/write at a time is issued to the
// traffic controller, with read data capture and an ack timeout.
module he_hssi_tc_mailbox #(
   parameter int TC_ADDR_W   = 16,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   he_hssi_tc_mailbox_if.slave mb
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   localparam logic [3:0] OFS_CMD    = 4'h0;
   localparam logic [3:0] OFS_ADDR   = 4'h4;
   localparam logic [3:0] OFS_RDDATA = 4'h8;
   localparam logic [3:0] OFS_WRDATA = 4'hC;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 rd_q, rd_d, wr_q, wr_d, ack_q, ack_d, busy_q, busy_d, err_q, err_d;
   logic [TC_ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]    wrdata_q, wrdata_d;
   logic [DATA_W-1:0]    rddata_q, rddata_d;
   logic [DATA_W-1:0]    csr_rdata_q, csr_rdata_d;
   logic                 csr_rdata_vld_q, csr_rdata_vld_d;
   logic                 tc_rd_q, tc_rd_d, tc_wr_q, tc_wr_d;
   logic [DATA_W-1:0]    cmd_val;

   assign cmd_val = {{(DATA_W-5){1'b0}}, err_q, busy_q, ack_q, wr_q, rd_q};

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      rd_d            = rd_q;
      wr_d            = wr_q;
      ack_d           = ack_q;
      busy_d          = busy_q;
      err_d           = err_q;
      addr_d          = addr_q;
      wrdata_d        = wrdata_q;
      rddata_d        = rddata_q;
      tc_rd_d         = 1'b0;
      tc_wr_d         = 1'b0;
      csr_rdata_vld_d = mb.csr_rd;
      csr_rdata_d     = '0;

      // Reads see only registered state, so a same-cycle completion is not visible yet.
      if (mb.csr_rd) begin
         case (mb.csr_addr)
            OFS_CMD:    csr_rdata_d = cmd_val;
            OFS_ADDR:   csr_rdata_d = DATA_W'(addr_q);
            OFS_RDDATA: csr_rdata_d = rddata_q;
            OFS_WRDATA: csr_rdata_d = wrdata_q;
            default:    csr_rdata_d = '0;
         endcase
      end

      if (mb.csr_wr && !busy_q) begin
         case (mb.csr_addr)
            OFS_ADDR:   addr_d   = mb.csr_wdata[TC_ADDR_W-1:0];
            OFS_WRDATA: wrdata_d = mb.csr_wdata;
            OFS_CMD: begin
               rd_d = mb.csr_wdata[0];
               wr_d = mb.csr_wdata[1];
               case (mb.csr_wdata[1:0])
                  2'b00: begin
                     ack_d = 1'b0;
                     err_d = 1'b0;
                  end
                  2'b11: begin
                     ack_d = 1'b1;
                     err_d = 1'b1;
                  end
                  default: begin
                     ack_d   = 1'b0;
                     err_d   = 1'b0;
                     busy_d  = 1'b1;
                     tc_rd_d = mb.csr_wdata[0];
                     tc_wr_d = mb.csr_wdata[1];
                     state_d = ST_ISSUE;
                  end
               endcase
            end
            default: ;
         endcase
      end

      case (state_q)
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mb.tc_ack) begin
               if (rd_q) rddata_d = mb.tc_rdata;
               ack_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               if (rd_q) rddata_d = '1;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         rd_q            <= 1'b0;
         wr_q            <= 1'b0;
         ack_q           <= 1'b0;
         busy_q          <= 1'b0;
         err_q           <= 1'b0;
         addr_q          <= '0;
         wrdata_q        <= '0;
         rddata_q        <= '0;
         csr_rdata_q     <= '0;
         csr_rdata_vld_q <= 1'b0;
         tc_rd_q         <= 1'b0;
         tc_wr_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         rd_q            <= rd_d;
         wr_q            <= wr_d;
         ack_q           <= ack_d;
         busy_q          <= busy_d;
         err_q           <= err_d;
         addr_q          <= addr_d;
         wrdata_q        <= wrdata_d;
         rddata_q        <= rddata_d;
         csr_rdata_q     <= csr_rdata_d;
         csr_rdata_vld_q <= csr_rdata_vld_d;
         tc_rd_q         <= tc_rd_d;
         tc_wr_q         <= tc_wr_d;
      end
   end

   assign mb.csr_rdata     = csr_rdata_q;
   assign mb.csr_rdata_vld = csr_rdata_vld_q;
   assign mb.tc_rd         = tc_rd_q;
   assign mb.tc_wr         = tc_wr_q;
   assign mb.tc_addr       = addr_q;
   assign mb.tc_wdata      = wrdata_q;
endmodule
